// File: rtl/rvfpm_commit_tracker_pkg.sv
// Shared XIF front-end types for the rvfpm commit tracker: the per-entry
// lifecycle state and the ring entry record.
package in_xif;

  // Widest XIF instruction ID any tracker instance may be built with. IDs are
  // stored zero-extended to this width so the entry record has a fixed layout.
  localparam int unsigned X_ID_WIDTH_MAX = 16;

  // Lifecycle of one tracked speculative instruction.
  typedef enum logic [2:0] {
    ST_EMPTY     = 3'd0,
    ST_SPEC      = 3'd1,
    ST_COMMITTED = 3'd2,
    ST_KILLED    = 3'd3,
    ST_DONE      = 3'd4
  } tracker_state_e;

  // One ring slot.
  typedef struct packed {
    logic [X_ID_WIDTH_MAX-1:0] id;
    tracker_state_e            state;
  } tracker_entry_t;

  // Entries that may still be matched by alloc/commit/retire/query. A DONE
  // entry only waits for its in-order pop and must not block reuse of its ID.
  function automatic logic is_live(input tracker_state_e s);
    return (s == ST_SPEC) || (s == ST_COMMITTED) || (s == ST_KILLED);
  endfunction

endpackage

// File: rtl/rvfpm_id_match.sv
// DEPTH-wide ID comparator: flags every live entry that holds i_id. The
// tracker never admits a duplicate live ID, so the result is one-hot or zero.
module rvfpm_id_match #(
  parameter int unsigned ID_W  = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic [ID_W-1:0]  i_id,
  input  logic [ID_W-1:0]  i_ids [DEPTH],
  input  logic [DEPTH-1:0] i_live,
  output logic [DEPTH-1:0] o_match
);

  // Per-entry compare, qualified by liveness.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_match[i] = i_live[i] && (i_ids[i] == i_id);
    end
  end

endmodule

// File: rtl/rvfpm_commit_tracker.sv
// Age-ordered tracker of speculative XIF issue IDs: records accepted issues,
// applies commit/kill, answers status queries, and frees retired entries in
// order from the head of the ring.
module rvfpm_commit_tracker
  import in_xif::*;
#(
  parameter  int unsigned X_ID_WIDTH   = 4,
  parameter  int unsigned DEPTH        = 8,
  parameter  bit          KILL_YOUNGER = 1'b0,
  localparam int unsigned PW           = $clog2(DEPTH),
  localparam int unsigned CW           = $clog2(DEPTH + 1)
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic [X_ID_WIDTH-1:0] alloc_id,
  output logic                  alloc_ready,
  input  logic                  commit_valid,
  input  logic [X_ID_WIDTH-1:0] commit_id,
  input  logic                  commit_kill,
  input  logic                  retire_valid,
  input  logic [X_ID_WIDTH-1:0] retire_id,
  input  logic [X_ID_WIDTH-1:0] query_id,
  output logic                  query_hit,
  output logic                  query_committed,
  output logic                  query_killed,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  err_dup,
  output logic                  err_commit_miss,
  output logic                  err_retire
);

  localparam int unsigned   IW   = X_ID_WIDTH_MAX;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  tracker_entry_t r_ent [DEPTH];
  logic [PW-1:0]  r_head, r_tail;
  logic [CW-1:0]  r_count;
  logic           r_err_dup, r_err_commit, r_err_retire;

  tracker_entry_t w_next [DEPTH];
  logic [IW-1:0]  w_ids [DEPTH];
  logic [PW-1:0]  w_off [DEPTH];
  logic [DEPTH-1:0] w_live, w_alloc_match, w_commit_match, w_retire_match, w_query_match;
  logic [DEPTH-1:0] w_tail_oh, w_cm, w_rm;
  logic [PW-1:0]  w_match_off;
  logic [CW-1:0]  w_count_pa;
  logic           w_ready, w_pop, w_alloc_do, w_commit_ok, w_retire_ok;

  // Flatten the ring for the comparators and compute each slot's age (0 = head).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ids[i]  = r_ent[i].id;
      w_live[i] = is_live(r_ent[i].state);
      w_off[i]  = PW'(i) - r_head;
    end
  end

  rvfpm_id_match #(.ID_W(IW), .DEPTH(DEPTH)) u_alloc_match (
    .i_id(IW'(alloc_id)), .i_ids(w_ids), .i_live(w_live), .o_match(w_alloc_match));
  rvfpm_id_match #(.ID_W(IW), .DEPTH(DEPTH)) u_commit_match (
    .i_id(IW'(commit_id)), .i_ids(w_ids), .i_live(w_live), .o_match(w_commit_match));
  rvfpm_id_match #(.ID_W(IW), .DEPTH(DEPTH)) u_retire_match (
    .i_id(IW'(retire_id)), .i_ids(w_ids), .i_live(w_live), .o_match(w_retire_match));
  rvfpm_id_match #(.ID_W(IW), .DEPTH(DEPTH)) u_query_match (
    .i_id(IW'(query_id)), .i_ids(w_ids), .i_live(w_live), .o_match(w_query_match));

  // Admission, pop and same-cycle forwarding of a fresh alloc to commit/retire.
  assign w_ready    = (r_count < FULL);
  assign w_pop      = (r_ent[r_head].state == ST_DONE);
  assign w_alloc_do = alloc_valid && w_ready && !(|w_alloc_match);
  assign w_tail_oh  = DEPTH'(1) << r_tail;
  assign w_cm       = w_commit_match | ((w_alloc_do && (commit_id == alloc_id)) ? w_tail_oh : '0);
  assign w_rm       = w_retire_match | ((w_alloc_do && (retire_id == alloc_id)) ? w_tail_oh : '0);
  assign w_count_pa = r_count + CW'(w_alloc_do);

  // Next ring contents, applied in priority order: pop, alloc, commit/kill, retire.
  // NOTE: every variable driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_next      = r_ent;
    w_match_off = '0;
    w_commit_ok = 1'b0;
    w_retire_ok = 1'b0;
    if (w_pop) w_next[r_head].state = ST_EMPTY;
    if (w_alloc_do) begin
      w_next[r_tail].id    = IW'(alloc_id);
      w_next[r_tail].state = ST_SPEC;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (commit_valid && w_cm[i]) begin
        w_match_off = w_off[i];
        if (commit_kill) begin
          if (w_next[i].state inside {ST_SPEC, ST_COMMITTED}) begin
            w_next[i].state = ST_KILLED;
            w_commit_ok     = 1'b1;
          end
        end else if (w_next[i].state == ST_SPEC) begin
          w_next[i].state = ST_COMMITTED;
          w_commit_ok     = 1'b1;
        end else if (w_next[i].state == ST_COMMITTED) begin
          w_commit_ok = 1'b1;
        end
      end
    end
    // Kill range: SPEC entries younger than the killed one, up to the new tail.
    if (KILL_YOUNGER && commit_valid && commit_kill && w_commit_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((w_off[i] > w_match_off) && (CW'(w_off[i]) < w_count_pa) &&
            (w_next[i].state == ST_SPEC)) begin
          w_next[i].state = ST_KILLED;
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (retire_valid && w_rm[i] && (w_next[i].state inside {ST_COMMITTED, ST_KILLED})) begin
        w_next[i].state = ST_DONE;
        w_retire_ok     = 1'b1;
      end
    end
  end

  // Ring, pointers, occupancy and one-cycle error pulses.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ck) begin
    if (!rst) begin
      // NOTE: only the state field is reset; an EMPTY slot's id is never
      // looked at, so clearing the id storage would buy nothing.
      for (int i = 0; i < DEPTH; i++) r_ent[i].state <= ST_EMPTY;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_err_dup    <= 1'b0;
      r_err_commit <= 1'b0;
      r_err_retire <= 1'b0;
    end else begin
      r_ent        <= w_next;
      r_head       <= r_head + PW'(w_pop);
      r_tail       <= r_tail + PW'(w_alloc_do);
      r_count      <= r_count + CW'(w_alloc_do) - CW'(w_pop);
      r_err_dup    <= alloc_valid && w_ready && (|w_alloc_match);
      r_err_commit <= commit_valid && !w_commit_ok;
      r_err_retire <= retire_valid && !w_retire_ok;
    end
  end

  // Status of the queried ID among live entries.
  always_comb begin
    query_committed = 1'b0;
    query_killed    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_query_match[i]) begin
        query_committed = query_committed | (r_ent[i].state == ST_COMMITTED);
        query_killed    = query_killed    | (r_ent[i].state == ST_KILLED);
      end
    end
  end

  assign query_hit       = |w_query_match;
  assign alloc_ready     = w_ready;
  assign count           = r_count;
  assign empty           = (r_count == '0);
  assign err_dup         = r_err_dup;
  assign err_commit_miss = r_err_commit;
  assign err_retire      = r_err_retire;

endmodule
